sram_arbiter: RTL and testbench

//  Shares one single-port SRAM (1-cycle read latency, per-bit write enable) among NUM_PORTS requesters.

---
 rtl/sram_arb_pkg.sv | 14 +
 rtl/sram_arb_rr.sv | 40 ++++
 rtl/sram_arbiter.sv | 153 +++++++++++++++
 tb/tb_sram_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared helpers for the SRAM arbiter slice.
//   addr_width(): address width for a given SRAM depth (at least 1 bit).
//   idx_width():  width of a port index for a given port count (at least 1 bit).
package sram_arb_pkg;

  function automatic int unsigned addr_width(input int unsigned num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// Round-robin pick: grants the first requesting port at or after rr_i,
// wrapping from NUM_PORTS-1 back to 0.
// Ports:
//   req_i  in  NUM_PORTS  request vector
//   rr_i   in  IDX_W      current round-robin pointer
//   gnt_o  out NUM_PORTS  one-hot grant (all zero when req_i is zero)
//   idx_o  out IDX_W      index of the granted port (0 when idle)
module sram_arb_rr
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     rr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     idx_o
);

  // NOTE: every output and local of this always_comb gets a default before
  // the loop, so no path leaves a value held and no latch is inferred.
  always_comb begin
    logic        found;
    int unsigned cand;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = int'(rr_i) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM (1-cycle read latency,
// bit-granular write enables) among NUM_PORTS requesters.
// Optional feature macro: SRAM_ARB_STALL_CNT_EN adds per-port saturating
// stall counters on stall_cnt_o.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_i/we_i/addr_i/wdata_i/be_i per-port request fields (flattened, port k
//                                  at slice [k*W +: W])
//   gnt_o                          same-cycle one-hot grant
//   rvalid_o                       read response strobe, routed to issuing port
//   rdata_o                        shared read data (pass-through of sram_rdata_i)
//   sram_*                         SRAM macro interface
//   stall_cnt_o                    per-port stall counters (macro only)
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_WORDS  = 1024,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = addr_width(NUM_WORDS)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_PORTS-1:0]             req_i,
  input  logic [NUM_PORTS-1:0]             we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  be_i,
  output logic [NUM_PORTS-1:0]             gnt_o,
  output logic [NUM_PORTS-1:0]             rvalid_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic                             sram_req_o,
  output logic                             sram_we_o,
  output logic [ADDR_WIDTH-1:0]            sram_addr_o,
  output logic [DATA_WIDTH-1:0]            sram_wdata_o,
  output logic [DATA_WIDTH-1:0]            sram_be_o,
  input  logic [DATA_WIDTH-1:0]            sram_rdata_i
`ifdef SRAM_ARB_STALL_CNT_EN
  ,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]   stall_cnt_o
`endif
);

  localparam int unsigned IDX_W = idx_width(NUM_PORTS);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] be;
  } req_t;

  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] gnt_idx;
  logic [NUM_PORTS-1:0] gnt;
  req_t             port_req [NUM_PORTS];
  req_t             sel_req;
  logic             rd_pend_q;
  logic [IDX_W-1:0] rd_idx_q;

  sram_arb_rr #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr (
    .req_i (req_i),
    .rr_i  (rr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign gnt_o = gnt;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_unpack
    assign port_req[k] = '{
      we:    we_i[k],
      addr:  addr_i[k*ADDR_WIDTH +: ADDR_WIDTH],
      wdata: wdata_i[k*DATA_WIDTH +: DATA_WIDTH],
      be:    be_i[k*DATA_WIDTH +: DATA_WIDTH]
    };
  end

  // Idle cycles drive all request fields to zero rather than holding the
  // last port's values, so the SRAM pins are quiet when nothing is granted.
  always_comb begin
    sel_req = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (gnt[k]) sel_req = port_req[k];
    end
  end

  assign sram_req_o   = |gnt;
  assign sram_we_o    = sel_req.we;
  assign sram_addr_o  = sel_req.addr;
  assign sram_wdata_o = sel_req.wdata;
  assign sram_be_o    = sel_req.be;

  // Pointer moves just past the accepted port; with one port it stays 0
  // because the granted index and NUM_PORTS-1 are both 0.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (|gnt) begin
      rr_q <= (gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  // One read can be outstanding per cycle; remember who issued it so the
  // response strobe reaches the right port one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pend_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      rd_pend_q <= (|gnt) && !sel_req.we;
      rd_idx_q  <= gnt_idx;
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      rvalid_o[k] = rd_pend_q && (rd_idx_q == IDX_W'(k));
    end
  end

  assign rdata_o = sram_rdata_i;

`ifdef SRAM_ARB_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q [NUM_PORTS];

  // NOTE: this register array is reset explicitly because software reads it
  // as a statistic; a data-storage array would normally be left unreset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) stall_cnt_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        if (req_i[k] && !gnt[k] && (stall_cnt_q[k] != '1)) begin
          stall_cnt_q[k] <= stall_cnt_q[k] + CNT_WIDTH'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_stall_out
    assign stall_cnt_o[k*CNT_WIDTH +: CNT_WIDTH] = stall_cnt_q[k];
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter (4 ports, 64-bit data, 1024 words).
// A behavioural SRAM with 1-cycle read latency sits on the sram_* pins.
module tb_sram_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int NW = 1024;
  localparam int AW = 10;
  localparam int CW = 4;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic [NP-1:0]    req, we, gnt, rvalid;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] wdata, be;
  logic [DW-1:0]    rdata;
  logic             sram_req, sram_we;
  logic [AW-1:0]    sram_addr;
  logic [DW-1:0]    sram_wdata, sram_be, sram_rdata;
`ifdef SRAM_ARB_STALL_CNT_EN
  logic [NP*CW-1:0] stall_cnt;
`endif

  sram_arbiter #(
    .NUM_PORTS  (NP),
    .DATA_WIDTH (DW),
    .NUM_WORDS  (NW),
    .CNT_WIDTH  (CW)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req),
    .we_i         (we),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .be_i         (be),
    .gnt_o        (gnt),
    .rvalid_o     (rvalid),
    .rdata_o      (rdata),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_be_o    (sram_be),
    .sram_rdata_i (sram_rdata)
`ifdef SRAM_ARB_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt)
`endif
  );

  // Behavioural SRAM model.
  logic [DW-1:0] mem [NW];
  initial begin
    for (int i = 0; i < NW; i++) mem[i] = '0;
    sram_rdata = '0;
  end
  always @(posedge clk_i) begin
    if (sram_req) begin
      if (sram_we) mem[sram_addr] <= (mem[sram_addr] & ~sram_be) | (sram_wdata & sram_be);
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_port(input int k, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] b);
    addr[k*AW +: AW]  = a;
    wdata[k*DW +: DW] = d;
    be[k*DW +: DW]    = b;
  endtask

  typedef struct {
    logic [3:0]    req;
    logic [3:0]    we;
    logic [3:0]    exp_gnt;
    logic [3:0]    exp_rvalid;
    logic [AW-1:0] exp_addr;
    logic          exp_we;
  } vec_t;

  vec_t vecs [16];

  initial begin
    rst_ni = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0; be = '0;

    // Port k uses address 16+k. rvalid in row i reflects the read accepted in row i-1.
    vecs[0]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 10'd0,  1'b0}; // idle after reset
    vecs[1]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0000, 10'd16, 1'b0}; // rr=0 -> port0
    vecs[2]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0001, 10'd17, 1'b0};
    vecs[3]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0010, 10'd18, 1'b0};
    vecs[4]  = '{4'b1111, 4'b0000, 4'b1000, 4'b0100, 10'd19, 1'b0};
    vecs[5]  = '{4'b1111, 4'b0000, 4'b0001, 4'b1000, 10'd16, 1'b0}; // wrap 3 -> 0
    vecs[6]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0001, 10'd17, 1'b0};
    vecs[7]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0010, 10'd18, 1'b0};
    vecs[8]  = '{4'b1111, 4'b0000, 4'b1000, 4'b0100, 10'd19, 1'b0}; // rr -> 0
    vecs[9]  = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 10'd17, 1'b1}; // port1 write, rr -> 2
    vecs[10] = '{4'b1010, 4'b0000, 4'b1000, 4'b0000, 10'd19, 1'b0}; // rr=2: port3; write gave no rvalid
    vecs[11] = '{4'b1010, 4'b0000, 4'b0010, 4'b1000, 10'd17, 1'b0}; // rr=0: port1, rr -> 2
    vecs[12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 10'd0,  1'b0}; // idle, rr holds 2
    vecs[13] = '{4'b1111, 4'b0000, 4'b0100, 4'b0000, 10'd18, 1'b0}; // rr=2 -> port2, rr -> 3
    vecs[14] = '{4'b0011, 4'b0000, 4'b0001, 4'b0100, 10'd16, 1'b0}; // rr=3 wraps to port0
    vecs[15] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 10'd0,  1'b0};

    for (int k = 0; k < NP; k++)
      set_port(k, AW'(16 + k), 64'hA5A5_0000_0000_0000 | DW'(k), '1);

    repeat (2) @(negedge clk_i);
    #1;
    check("reset_rvalid", 64'(rvalid), 64'h0);
    check("reset_sram_req", 64'(sram_req), 64'h0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Table-driven arbitration vectors.
    for (int i = 0; i < 16; i++) begin
      req = vecs[i].req;
      we  = vecs[i].we;
      #1;
      check($sformatf("vec%0d_gnt", i),      64'(gnt),       64'(vecs[i].exp_gnt));
      check($sformatf("vec%0d_rvalid", i),   64'(rvalid),    64'(vecs[i].exp_rvalid));
      check($sformatf("vec%0d_sram_req", i), 64'(sram_req),  64'(|vecs[i].exp_gnt));
      check($sformatf("vec%0d_sram_addr", i),64'(sram_addr), 64'(vecs[i].exp_addr));
      check($sformatf("vec%0d_sram_we", i),  64'(sram_we),   64'(vecs[i].exp_we));
      @(negedge clk_i);
    end
    req = '0; we = '0;
    #1;
    check("after_table_rvalid", 64'(rvalid), 64'h0);

    // Write 0xDEADBEEF to addr 5, read it back.
    @(negedge clk_i);
    set_port(0, 10'd5, 64'hDEAD_BEEF, '1);
    req = 4'b0001; we = 4'b0001;
    #1;
    check("wr5_gnt", 64'(gnt), 64'h1);
    check("wr5_sram_wdata", sram_wdata, 64'hDEAD_BEEF);
    @(negedge clk_i);
    we = 4'b0000;
    #1;
    check("rd5_gnt", 64'(gnt), 64'h1);
    check("rd5_rvalid_not_yet", 64'(rvalid), 64'h0);
    @(negedge clk_i);
    req = '0;
    #1;
    check("rd5_rvalid", 64'(rvalid), 64'h1);
    check("rd5_rdata", rdata, 64'hDEAD_BEEF);
    @(negedge clk_i);
    #1;
    check("rd5_rvalid_one_cycle", 64'(rvalid), 64'h0);

    // Bit-enable write: zero addr 9, write all-ones with be=0xFF, read back.
    @(negedge clk_i);
    set_port(0, 10'd9, '0, '1);
    req = 4'b0001; we = 4'b0001;
    @(negedge clk_i);
    set_port(0, 10'd9, '1, 64'h0000_0000_0000_00FF);
    #1;
    check("be_wr_sram_be", sram_be, 64'h0000_0000_0000_00FF);
    @(negedge clk_i);
    we = 4'b0000;
    @(negedge clk_i);
    req = '0;
    #1;
    check("be_rd_rvalid", 64'(rvalid), 64'h1);
    check("be_rd_rdata", rdata, 64'h0000_0000_0000_00FF);

    // Reset while a read is in flight.
    @(negedge clk_i);
    req = 4'b0100;
    #1;
    check("rst_rd_gnt", 64'(gnt), 64'h4);
    @(negedge clk_i);
    req = '0;
    #1;
    check("rst_rvalid_before", 64'(rvalid), 64'h4);
    rst_ni = 1'b0;
    #1;
    check("rst_rvalid_async", 64'(rvalid), 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    req = 4'b1111;
    #1;
    check("rst_rr_zero_gnt", 64'(gnt), 64'h1);
    check("rst_read_dropped", 64'(rvalid), 64'h0);
    @(negedge clk_i);
    req = '0;

`ifdef SRAM_ARB_STALL_CNT_EN
    // Stall counters with all ports contending: port1 stalls 3 of every 4 cycles.
    rst_ni = 1'b0;
    #1;
    check("stall_reset", 64'(stall_cnt), 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    req = 4'b1111;
    repeat (4) @(negedge clk_i);
    #1;
    check("stall_p1_4cyc", 64'(stall_cnt[1*CW +: CW]), 64'd3);
    check("stall_p3_4cyc", 64'(stall_cnt[3*CW +: CW]), 64'd3);
    repeat (24) @(negedge clk_i);
    #1;
    check("stall_p1_sat", 64'(stall_cnt[1*CW +: CW]), 64'd15);
    @(negedge clk_i);
    #1;
    check("stall_p1_hold", 64'(stall_cnt[1*CW +: CW]), 64'd15);
    req = '0;
    @(negedge clk_i);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
